// File: rtl/aes128_pkg.sv
// Shared types, constants and the GF(2^8) doubling helper for the AES-128 key schedule.
package aes128_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;
    localparam logic [3:0] LAST_IDX  = 4'd10;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_sbox.sv
// Forward AES S-box, purely combinational; four copies form SubWord in the key schedule.
module aes128_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes128_key_expand.sv
// Sequential AES-128 key schedule: one round key per RK handshake, next key computed in one cycle.
// Build option AES_KEYEXP_ZEROIZE_EN clears the working register on every return to IDLE.
module aes128_key_expand
    import aes128_pkg::*;
(
    input  logic         CLK,
    input  logic         RSTB,
    input  logic [127:0] KEY_IN,
    input  logic         KEY_VLD,
    output logic         KEY_RDY,
    input  logic         ABORT,
    output logic [127:0] RK_OUT,
    output logic [3:0]   RK_IDX,
    output logic         RK_LAST,
    output logic         RK_VLD,
    input  logic         RK_RDY
);

`ifdef AES_KEYEXP_ZEROIZE_EN
    localparam logic ZEROIZE = 1'b1;
`else
    localparam logic ZEROIZE = 1'b0;
`endif

    state_e       state_q;
    logic [127:0] work_q;
    logic [3:0]   idx_q;
    logic [7:0]   rcon_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  w0_d, w1_d, w2_d, w3_d;
    logic [127:0] work_d;

    assign {w0, w1, w2, w3} = work_q;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes128_sbox u_sbox (
            .byte_i (rot_w[8*b +: 8]),
            .byte_o (sub_w[8*b +: 8])
        );
    end

    assign t_w    = sub_w ^ {rcon_q, 24'h0};
    assign w0_d   = w0 ^ t_w;
    assign w1_d   = w1 ^ w0_d;
    assign w2_d   = w2 ^ w1_d;
    assign w3_d   = w3 ^ w2_d;
    assign work_d = {w0_d, w1_d, w2_d, w3_d};

    // ABORT outranks both handshakes; in IDLE it only blocks key acceptance.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
        end else if (ABORT) begin
            if (state_q == ST_EMIT) begin
                state_q <= ST_IDLE;
                if (ZEROIZE) work_q <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (KEY_VLD) begin
                        work_q  <= KEY_IN;
                        idx_q   <= '0;
                        rcon_q  <= RCON_INIT;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (RK_RDY) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_IDLE;
                            if (ZEROIZE) work_q <= '0;
                        end else begin
                            work_q <= work_d;
                            idx_q  <= idx_q + 4'd1;
                            rcon_q <= xtime(rcon_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign KEY_RDY = (state_q == ST_IDLE);
    assign RK_VLD  = (state_q == ST_EMIT);
    assign RK_LAST = (state_q == ST_EMIT) && (idx_q == LAST_IDX);
    assign RK_OUT  = work_q;
    assign RK_IDX  = idx_q;

endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for aes128_key_expand: FIPS-197 and zero-key vectors, backpressure, abort, reset.
module tb_aes128_key_expand;

    logic         CLK;
    logic         RSTB;
    logic [127:0] KEY_IN;
    logic         KEY_VLD;
    logic         KEY_RDY;
    logic         ABORT;
    logic [127:0] RK_OUT;
    logic [3:0]   RK_IDX;
    logic         RK_LAST;
    logic         RK_VLD;
    logic         RK_RDY;

`ifdef AES_KEYEXP_ZEROIZE_EN
    localparam bit ZER = 1'b1;
`else
    localparam bit ZER = 1'b0;
`endif

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] fips [0:10];

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;
    vec_t vecs [6];

    aes128_key_expand dut (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .KEY_IN  (KEY_IN),
        .KEY_VLD (KEY_VLD),
        .KEY_RDY (KEY_RDY),
        .ABORT   (ABORT),
        .RK_OUT  (RK_OUT),
        .RK_IDX  (RK_IDX),
        .RK_LAST (RK_LAST),
        .RK_VLD  (RK_VLD),
        .RK_RDY  (RK_RDY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer a key and wait (bounded) for it to be taken; returns one step after acceptance.
    task automatic load_key(input logic [127:0] key);
        int w;
        KEY_IN  = key;
        KEY_VLD = 1'b1;
        w = 0;
        while (KEY_RDY !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        if (w >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL load_key_timeout: got KEY_RDY=%b expected 1", KEY_RDY);
        end
        step();
        KEY_VLD = 1'b0;
    endtask

    // Check rounds from_k..10 with RK_RDY high, then the idle state that follows.
    task automatic run_fips_from(input int from_k);
        for (int k = from_k; k <= 10; k++) begin
            chk($sformatf("vld_k%0d", k), RK_VLD, 1'b1);
            chk($sformatf("idx_k%0d", k), RK_IDX, k[3:0]);
            chk($sformatf("rk_k%0d", k), RK_OUT, fips[k]);
            chk($sformatf("last_k%0d", k), RK_LAST, (k == 10));
            step();
        end
        chk("done_key_rdy", KEY_RDY, 1'b1);
        chk("done_rk_vld", RK_VLD, 1'b0);
        chk("done_rk_last", RK_LAST, 1'b0);
        chk("done_rk_out", RK_OUT, ZER ? 128'h0 : fips[10]);
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{key: FIPS_KEY, idx: 1,  rk: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{key: FIPS_KEY, idx: 5,  rk: 128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[2] = '{key: FIPS_KEY, idx: 9,  rk: 128'hac7766f319fadc2128d12941575c006e};
        vecs[3] = '{key: 128'h0,   idx: 1,  rk: 128'h62636363626363636263636362636363};
        vecs[4] = '{key: 128'h0,   idx: 2,  rk: 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
        vecs[5] = '{key: FIPS_KEY, idx: 10, rk: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        RSTB    = 1'b0;
        KEY_IN  = '0;
        KEY_VLD = 1'b0;
        ABORT   = 1'b0;
        RK_RDY  = 1'b0;
        repeat (3) step();
        chk("rst_key_rdy", KEY_RDY, 1'b1);
        chk("rst_rk_vld", RK_VLD, 1'b0);
        chk("rst_rk_last", RK_LAST, 1'b0);
        chk("rst_rk_out", RK_OUT, 128'h0);
        chk("rst_rk_idx", RK_IDX, 4'd0);
        RSTB = 1'b1;
        step();

        // Full FIPS-197 schedule, consumer always ready: 11 consecutive valid cycles.
        RK_RDY = 1'b1;
        load_key(FIPS_KEY);
        run_fips_from(0);

        // Table: advance to an index, hold it, then abort out of it.
        foreach (vecs[i]) begin
            RK_RDY = 1'b0;
            load_key(vecs[i].key);
            RK_RDY = 1'b1;
            repeat (vecs[i].idx) step();
            RK_RDY = 1'b0;
            step();
            chk($sformatf("vec%0d_idx", i), RK_IDX, vecs[i].idx[3:0]);
            chk($sformatf("vec%0d_rk", i), RK_OUT, vecs[i].rk);
            ABORT = 1'b1;
            step();
            ABORT = 1'b0;
            chk($sformatf("vec%0d_abort_rdy", i), KEY_RDY, 1'b1);
            chk($sformatf("vec%0d_abort_out", i), RK_OUT, ZER ? 128'h0 : vecs[i].rk);
        end

        // Zero key: KEY_RDY returns the cycle after the idx10 handshake.
        RK_RDY = 1'b1;
        load_key(128'h0);
        repeat (10) step();
        chk("zero_idx10", RK_IDX, 4'd10);
        chk("zero_last", RK_LAST, 1'b1);
        chk("zero_key_rdy_before", KEY_RDY, 1'b0);
        step();
        chk("zero_key_rdy_after", KEY_RDY, 1'b1);
        chk("zero_vld_after", RK_VLD, 1'b0);

        // Backpressure at idx4 for three cycles.
        RK_RDY = 1'b1;
        load_key(FIPS_KEY);
        repeat (4) step();
        RK_RDY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("bp_idx_c%0d", c), RK_IDX, 4'd4);
            chk($sformatf("bp_rk_c%0d", c), RK_OUT, fips[4]);
            chk($sformatf("bp_vld_c%0d", c), RK_VLD, 1'b1);
        end
        RK_RDY = 1'b1;
        run_fips_from(4);

        // ABORT at idx6 with RK_RDY high; then RCON must restart from 01.
        load_key(FIPS_KEY);
        repeat (6) step();
        chk("ab_idx6", RK_IDX, 4'd6);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("ab_vld", RK_VLD, 1'b0);
        chk("ab_key_rdy", KEY_RDY, 1'b1);
        chk("ab_out", RK_OUT, ZER ? 128'h0 : fips[6]);
        load_key(FIPS_KEY);
        chk("ab_new_idx0", RK_OUT, fips[0]);
        step();
        chk("ab_new_idx1", RK_OUT, fips[1]);
        step();
        chk("ab_new_idx2", RK_OUT, fips[2]);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;

        // ABORT in IDLE blocks an offered key.
        KEY_IN  = 128'h0123456789abcdef0123456789abcdef;
        KEY_VLD = 1'b1;
        ABORT   = 1'b1;
        step();
        ABORT   = 1'b0;
        KEY_VLD = 1'b0;
        chk("idle_abort_rdy", KEY_RDY, 1'b1);
        chk("idle_abort_vld", RK_VLD, 1'b0);

        // Asynchronous reset at idx3.
        load_key(FIPS_KEY);
        repeat (3) step();
        chk("rm_idx3", RK_IDX, 4'd3);
        #2 RSTB = 1'b0;
        #1;
        chk("rm_key_rdy", KEY_RDY, 1'b1);
        chk("rm_vld", RK_VLD, 1'b0);
        chk("rm_last", RK_LAST, 1'b0);
        chk("rm_out", RK_OUT, 128'h0);
        chk("rm_idx", RK_IDX, 4'd0);
        step();
        RSTB = 1'b1;
        step();
        load_key(FIPS_KEY);
        run_fips_from(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes128_key_expand.md
# aes128_key_expand

Sequential AES-128 key schedule. Accepts one 128-bit cipher key and emits the 11 round keys (index 0..10) one per handshake, computing each next key on the fly from the current one. Sits directly upstream of the gate-level round datapath, which consumes one round key per round via a valid/ready interface.

## Interface
- No parameters; AES-128 only, with a fixed 10-round schedule.
- CLK  in  1  rising-edge clock
- RSTB  in  1  reset; asynchronous, active-low
- KEY_IN  in  128  cipher key; bits [127:96] are word w0
- KEY_VLD  in  1  KEY_IN is valid
- KEY_RDY  out  1  block is idle and can accept a key
- ABORT  in  1  synchronous cancel of the current schedule
- RK_OUT  out  128  current round key
- RK_IDX  out  4  round index of RK_OUT, 0..10
- RK_LAST  out  1  high when RK_IDX==10 and RK_VLD is high
- RK_VLD  out  1  RK_OUT is valid
- RK_RDY  in  1  consumer accepts RK_OUT

## Operation
- States:
  - IDLE: KEY_RDY=1, RK_VLD=0.
  - EMIT: KEY_RDY=0, RK_VLD=1.
- Key handshake: KEY_VLD&&KEY_RDY&&!ABORT.
  - Effect: working reg <= KEY_IN, RK_IDX <= 0, RCON reg <= 8'h01, state <= EMIT.
- Round-key handshake: RK_VLD&&RK_RDY.
  - If RK_IDX<10: working reg <= expand(working reg, RCON), RK_IDX++, RCON <= xtime(RCON), stay in EMIT.
  - If RK_IDX==10: state <= IDLE.
- Expand rules:
  - t = SubWord(RotWord(w3)) ^ {RCON,24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
- RCON sequence: 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
- Outputs: RK_OUT is the working register directly. KEY_RDY and RK_VLD decode from state only, with no combinational path from inputs.
- Backpressure: while RK_RDY=0, RK_OUT, RK_IDX and RCON hold.
- ABORT in EMIT: state <= IDLE next cycle, regardless of RK_RDY. No key is consumed.
- ABORT in IDLE: an offered key is not accepted, even though KEY_RDY=1 that cycle.
- ABORT has priority over every handshake in the same cycle.
- KEY_VLD while in EMIT: ignored. The producer must hold it until KEY_RDY.
- Reset values: state IDLE, KEY_RDY=1, RK_VLD=0, RK_LAST=0, RK_OUT=0, RK_IDX=0, RCON=8'h01.
- Reset mid-schedule: the block returns to IDLE immediately; no partial state survives.

## Timing
- Key accepted at edge N: RK_VLD=1 with RK_IDX=0 (RK_OUT=KEY_IN) after edge N.
- RK_RDY held high: one round key per cycle. Index k is valid during cycle N+1+k; index 10 is valid during N+11.
- Last handshake at edge M: KEY_RDY=1 after M. The next key can be accepted at edge M+1, so keys cannot overlap.
- Next-key logic is single-cycle: 4 S-box lookups plus XOR chain from the working register back to itself.

## Configuration
- AES_KEYEXP_ZEROIZE_EN defined:
  - Every transition EMIT->IDLE, whether by the last handshake or by ABORT, also clears the working register to 0.
  - RK_OUT therefore reads 0 in IDLE.
- Undefined: the working register keeps its last value in IDLE. RK_OUT then shows round key 10, or the aborted key.
- RK_VLD, handshake behaviour and latency are identical in both builds.

## Structure
- Package aes128_pkg holds:
  - the state enum
  - the constants RCON_INIT=8'h01, RCON_POLY=8'h1b, LAST_IDX=4'd10
  - the xtime function
- Sub-module aes128_sbox: combinational, 8-bit in/out, forward S-box. Instantiated 4 times for SubWord.
- The control FSM, counter, RCON register and XOR chain live in aes128_key_expand.

## Test plan
- FIPS-197 App. A, RK_RDY=1, key 2b7e151628aed2a6abf7158809cf4f3c:
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - RK_LAST high only on idx10
  - 11 consecutive valid cycles
- Zero key:
  - idx1 = 62636363626363636263636362636363
  - KEY_RDY high the cycle after the idx10 handshake
- Backpressure: RK_RDY low for 3 cycles while idx4 is presented → RK_OUT and RK_IDX stable; the remaining keys still match FIPS.
- ABORT at idx6 → RK_VLD=0 and KEY_RDY=1 next cycle. A new FIPS key then gives the correct idx1, proving RCON restarted at 01.
- RSTB asserted mid-schedule (idx3) → all outputs at reset values immediately. After release, a full schedule is correct.
- AES_KEYEXP_ZEROIZE_EN on vs off:
  - after the last handshake, RK_OUT = 0 (on) vs d014…0ca6 (off)
  - after an abort, RK_OUT = 0 (on) vs the aborted key (off)
